poly_mau: RTL and testbench

//  Pipelined modular arithmetic unit of the polynomial core (Kyber/Dilithium).
//  Per enabled cycle it takes up to four coefficients, applies the op chosen by poly_alu_mode
//  (add, sub, pointwise multiply with Barrett reduction, compress/decompress, decompose).
//  It returns two coefficients a fixed number of cycles later. Modulus and Barrett constants are run-time inputs.

---
 rtl/poly_mau.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_poly_mau.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/poly_mau.sv
// poly_mau: pipelined modular arithmetic unit (add/sub, Barrett multiply, compress/decompress, decompose).
// Build option POLY_MAU_OUTREG_EN adds one output register stage (latency 4 instead of 3).
module poly_mau #(
    parameter int unsigned DATA_WIDTH = 24,
`ifdef POLY_MAU_OUTREG_EN
    parameter int unsigned LATENCY    = 4
`else
    parameter int unsigned LATENCY    = 3
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  poly_kd_sel,
    input  logic                  poly_pwm2_odd_even_sel,
    input  logic [1:0]            poly_duv_mode,
    input  logic [3:0]            poly_alu_mode,
    input  logic [1:0]            poly_compress,
    input  logic [1:0]            poly_decompose,
    input  logic [DATA_WIDTH-1:0] poly_mau_a,
    input  logic [DATA_WIDTH-1:0] poly_mau_b,
    input  logic [DATA_WIDTH-1:0] poly_mau_c,
    input  logic [DATA_WIDTH-1:0] poly_mau_d,
    input  logic [DATA_WIDTH-1:0] poly_q,
    input  logic [DATA_WIDTH:0]   poly_barret_m,
    input  logic [4:0]            poly_mm_N,
    input  logic                  poly_enable,
    output logic                  poly_valid,
    output logic [DATA_WIDTH-1:0] poly_mau_o0,
    output logic [DATA_WIDTH-1:0] poly_mau_o1
);
    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned PW = 2 * W;
    localparam int unsigned MW = PW + W + 1;
    localparam int unsigned RW = W + 2;
    localparam int unsigned DW = W + 6;
    localparam int unsigned XW = W + 2;

    typedef enum logic [2:0] {OP_DIRECT, OP_RED, OP_RED_SUM, OP_COMP, OP_DCMP} op_e;

    function automatic logic [W-1:0] mod_add(input logic [W-1:0] x, y, m);
        logic [W:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= {1'b0, m}) s = s - {1'b0, m};
        return s[W-1:0];
    endfunction

    function automatic logic [W-1:0] mod_sub(input logic [W-1:0] x, y, m);
        logic [W:0] s;
        s = {1'b0, x} - {1'b0, y};
        if (s[W]) s = s + {1'b0, m};
        return s[W-1:0];
    endfunction

    // t*q <= p always holds, so the difference is exact modulo 2^PW
    function automatic logic [RW-1:0] bar_raw(input logic [PW-1:0] p, t, input logic [W-1:0] m);
        logic [PW-1:0] tq;
        tq = t * PW'(m);
        return RW'(p - tq);
    endfunction

    function automatic logic [W-1:0] bar_fix(input logic [RW-1:0] r, input logic [W-1:0] m);
        logic [RW-1:0] x;
        x = r;
        if (x >= RW'(m)) x = x - RW'(m);
        if (x >= RW'(m)) x = x - RW'(m);
        return x[W-1:0];
    endfunction

    logic [3:0]    dbits;
    logic [W-1:0]  qm1, alpha, half;
    logic          pwm2_swap;
    logic [W-1:0]  x0, y0, x1, y1;
    logic [PW-1:0] prod0, prod1;

    always_comb begin
        unique case (poly_duv_mode)
            2'b00:   dbits = 4'd10;
            2'b01:   dbits = 4'd11;
            2'b10:   dbits = 4'd4;
            default: dbits = 4'd5;
        endcase
    end

    assign qm1   = poly_q - W'(1);
    assign alpha = (poly_decompose == 2'b11) ? (qm1 >> 4) : (qm1 / W'(44));
    assign half  = alpha >> 1;

    // MAP reuses multiplier 0 for a*q (decompress)
    always_comb begin
        pwm2_swap = (poly_alu_mode == 4'b0101) && poly_pwm2_odd_even_sel;
        x0 = poly_mau_a;
        y0 = pwm2_swap ? poly_mau_d : poly_mau_b;
        x1 = pwm2_swap ? poly_mau_b : poly_mau_c;
        y1 = pwm2_swap ? poly_mau_c : poly_mau_d;
        if (poly_alu_mode == 4'b1000) y0 = poly_q;
    end

    assign prod0 = PW'(x0) * PW'(y0);
    assign prod1 = PW'(x1) * PW'(y1);

    logic [LATENCY-1:0] vld_d, vld_q;
    op_e                op1_d, op1_q, op2_d, op2_q;
    logic [PW-1:0]      p0_1_d, p0_1_q, p1_1_d, p1_1_q;
    logic [PW-1:0]      p0_2_d, p0_2_q, p1_2_d, p1_2_q;
    logic [PW-1:0]      t0_d, t0_q, t1_d, t1_q;
    logic [5:0]         dk_d, dk_q;
    logic [XW-1:0]      drem_d, drem_q;
    logic [W-1:0]       o0_d, o0_q, o1_d, o1_q;

    assign vld_d = {vld_q[LATENCY-2:0], poly_enable};

    // Stage 1: operand selection, products, add/sub and decompress
    always_comb begin
        op1_d  = op1_q;
        p0_1_d = p0_1_q;
        p1_1_d = p1_1_q;
        if (poly_enable) begin
            op1_d  = OP_DIRECT;
            p0_1_d = '0;
            p1_1_d = '0;
            unique case (poly_alu_mode)
                4'b0000: begin
                    p0_1_d = PW'(mod_add(poly_mau_a, poly_mau_b, poly_q));
                    p1_1_d = PW'(mod_add(poly_mau_c, poly_mau_d, poly_q));
                end
                4'b0001: begin
                    p0_1_d = PW'(mod_sub(poly_mau_a, poly_mau_b, poly_q));
                    p1_1_d = PW'(mod_sub(poly_mau_c, poly_mau_d, poly_q));
                end
                4'b0100, 4'b0101: begin
                    op1_d  = (poly_alu_mode == 4'b0100) ? OP_RED : OP_RED_SUM;
                    p0_1_d = prod0;
                    p1_1_d = prod1;
                end
                4'b1000: begin
                    p0_1_d = PW'(poly_mau_a);
                    if (!poly_kd_sel) begin
                        if (poly_compress == 2'b01) begin
                            op1_d  = OP_COMP;
                            p0_1_d = (PW'(poly_mau_a) << dbits) + PW'(poly_q >> 1);
                        end else if (poly_compress == 2'b11) begin
                            p0_1_d = (prod0 + (PW'(1) << (dbits - 4'd1))) >> dbits;
                        end
                    end else if (poly_decompose == 2'b01 || poly_decompose == 2'b11) begin
                        op1_d = OP_DCMP;
                    end
                end
                default: ;
            endcase
        end
    end

    logic [5:0]    sh2n;
    logic [MW-1:0] pm0, pm1;
    logic [DW-1:0] drem;
    logic [5:0]    dk;

    assign sh2n = {poly_mm_N, 1'b0};
    assign pm0  = MW'(p0_1_q) * MW'(poly_barret_m);
    assign pm1  = MW'(p1_1_q) * MW'(poly_barret_m);

    // Decompose quotient is below 64, so a 6-step restoring divide by alpha suffices
    always_comb begin
        drem = DW'(p0_1_q[W-1:0]) + DW'(half) - DW'(1);
        dk   = '0;
        for (int unsigned i = 0; i < 6; i++) begin
            if (drem >= (DW'(alpha) << (5 - i))) begin
                drem = drem - (DW'(alpha) << (5 - i));
                dk   = {dk[4:0], 1'b1};
            end else begin
                dk   = {dk[4:0], 1'b0};
            end
        end
    end

    // Stage 2: Barrett quotient estimate and decompose division
    always_comb begin
        op2_d  = op2_q;
        p0_2_d = p0_2_q;
        p1_2_d = p1_2_q;
        t0_d   = t0_q;
        t1_d   = t1_q;
        dk_d   = dk_q;
        drem_d = drem_q;
        if (vld_q[0]) begin
            op2_d  = op1_q;
            p0_2_d = p0_1_q;
            p1_2_d = p1_1_q;
            t0_d   = PW'(pm0 >> sh2n);
            t1_d   = PW'(pm1 >> sh2n);
            dk_d   = dk;
            drem_d = XW'(drem);
        end
    end

    logic [RW-1:0] raw0, raw1;
    logic [W-1:0]  red0, red1, quot0, cmask;
    logic [XW-1:0] dr0, dka;
    logic [W-1:0]  dr1;

    assign raw0  = bar_raw(p0_2_q, t0_q, poly_q);
    assign raw1  = bar_raw(p1_2_q, t1_q, poly_q);
    assign red0  = bar_fix(raw0, poly_q);
    assign red1  = bar_fix(raw1, poly_q);
    assign quot0 = t0_q[W-1:0] + W'(raw0 >= RW'(poly_q)) + W'(raw0 >= RW'({poly_q, 1'b0}));
    assign cmask = (W'(1) << dbits) - W'(1);

    always_comb begin
        dr0 = XW'(drem_q) - XW'(half) + XW'(1);
        dka = XW'(p0_2_q[W-1:0]) - dr0;
        dr1 = W'(dk_q);
        if (dka == XW'(qm1)) begin
            dr1 = '0;
            dr0 = dr0 - XW'(1);
        end
        if (dr0[XW-1]) dr0 = dr0 + XW'(poly_q);
    end

    // Stage 3: final corrections; outputs hold across bubbles
    always_comb begin
        o0_d = o0_q;
        o1_d = o1_q;
        if (vld_q[1]) begin
            unique case (op2_q)
                OP_RED: begin
                    o0_d = red0;
                    o1_d = red1;
                end
                OP_RED_SUM: begin
                    o0_d = mod_add(red0, red1, poly_q);
                    o1_d = '0;
                end
                OP_COMP: begin
                    o0_d = quot0 & cmask;
                    o1_d = '0;
                end
                OP_DCMP: begin
                    o0_d = dr1;
                    o1_d = dr0[W-1:0];
                end
                default: begin
                    o0_d = p0_2_q[W-1:0];
                    o1_d = p1_2_q[W-1:0];
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            op1_q  <= OP_DIRECT;
            op2_q  <= OP_DIRECT;
            p0_1_q <= '0;
            p1_1_q <= '0;
            p0_2_q <= '0;
            p1_2_q <= '0;
            t0_q   <= '0;
            t1_q   <= '0;
            dk_q   <= '0;
            drem_q <= '0;
            o0_q   <= '0;
            o1_q   <= '0;
        end else begin
            vld_q  <= vld_d;
            op1_q  <= op1_d;
            op2_q  <= op2_d;
            p0_1_q <= p0_1_d;
            p1_1_q <= p1_1_d;
            p0_2_q <= p0_2_d;
            p1_2_q <= p1_2_d;
            t0_q   <= t0_d;
            t1_q   <= t1_d;
            dk_q   <= dk_d;
            drem_q <= drem_d;
            o0_q   <= o0_d;
            o1_q   <= o1_d;
        end
    end

    assign poly_valid = vld_q[LATENCY-1];

`ifdef POLY_MAU_OUTREG_EN
    logic [W-1:0] or0_d, or0_q, or1_d, or1_q;

    assign or0_d = o0_q;
    assign or1_d = o1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            or0_q <= '0;
            or1_q <= '0;
        end else begin
            or0_q <= or0_d;
            or1_q <= or1_d;
        end
    end

    assign poly_mau_o0 = or0_q;
    assign poly_mau_o1 = or1_q;
`else
    assign poly_mau_o0 = o0_q;
    assign poly_mau_o1 = o1_q;
`endif

endmodule

// File: tb/tb_poly_mau.sv
// Directed self-checking bench for poly_mau; expected values are hand-computed.
module tb_poly_mau;
`ifdef POLY_MAU_OUTREG_EN
    localparam int unsigned LAT = 4;
`else
    localparam int unsigned LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        kd, sel;
    logic [1:0]  duv, comp, dcmp;
    logic [3:0]  alu;
    logic [23:0] a, b, c, d, q;
    logic [24:0] m;
    logic [4:0]  n;
    logic        en;
    logic        valid;
    logic [23:0] o0, o1;

    int total = 0;
    int bad   = 0;

    poly_mau dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .poly_kd_sel            (kd),
        .poly_pwm2_odd_even_sel (sel),
        .poly_duv_mode          (duv),
        .poly_alu_mode          (alu),
        .poly_compress          (comp),
        .poly_decompose         (dcmp),
        .poly_mau_a             (a),
        .poly_mau_b             (b),
        .poly_mau_c             (c),
        .poly_mau_d             (d),
        .poly_q                 (q),
        .poly_barret_m          (m),
        .poly_mm_N              (n),
        .poly_enable            (en),
        .poly_valid             (valid),
        .poly_mau_o0            (o0),
        .poly_mau_o1            (o1)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ev, input logic [23:0] e0, input logic [23:0] e1);
        chk({tag, ".valid"}, {47'd0, valid}, {47'd0, ev});
        chk({tag, ".o0"}, {24'd0, o0}, {24'd0, e0});
        chk({tag, ".o1"}, {24'd0, o1}, {24'd0, e1});
    endtask

    task automatic issue(input logic [3:0] mode, input logic [23:0] ia, ib, ic, id);
        alu = mode;
        a = ia; b = ib; c = ic; d = id;
        en = 1'b1;
        step();
        en = 1'b0;
    endtask

    task automatic run(input logic [3:0] mode, input logic [23:0] ia, ib, ic, id);
        issue(mode, ia, ib, ic, id);
        repeat (LAT - 1) step();
    endtask

    initial begin
        rst_n = 1'b0;
        kd = 1'b0; sel = 1'b0; duv = 2'b00; comp = 2'b00; dcmp = 2'b00;
        alu = 4'b0000; a = '0; b = '0; c = '0; d = '0;
        q = 24'd3329; m = 25'd5039; n = 5'd12; en = 1'b0;
        #2;
        chk_out("reset", 1'b0, 24'd0, 24'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("idle.valid", {47'd0, valid}, 48'd0);

        run(4'b0000, 24'd3000, 24'd1000, 24'd100, 24'd200);
        chk_out("add", 1'b1, 24'd671, 24'd300);
        run(4'b0001, 24'd5, 24'd10, 24'd3328, 24'd0);
        chk_out("sub", 1'b1, 24'd3324, 24'd3328);

        // three back-to-back multiplies, results on consecutive cycles
        alu = 4'b0100; b = 24'd2773; c = 24'd3328; d = 24'd3328;
        en = 1'b1;
        a = 24'd245;  step();
        a = 24'd1603; step();
        a = 24'd497;  step();
        en = 1'b0;
        repeat (LAT - 3) step();
        chk_out("pwm0", 1'b1, 24'd269, 24'd1);
        step();
        chk_out("pwm1", 1'b1, 24'd904, 24'd1);
        step();
        chk_out("pwm2", 1'b1, 24'd3304, 24'd1);
        step();
        chk_out("pwm.bubble", 1'b0, 24'd3304, 24'd1);

        sel = 1'b0;
        run(4'b0101, 24'd2, 24'd3, 24'd4, 24'd5);
        chk_out("pwm2.even", 1'b1, 24'd26, 24'd0);
        sel = 1'b1;
        run(4'b0101, 24'd2, 24'd3, 24'd4, 24'd5);
        chk_out("pwm2.odd", 1'b1, 24'd22, 24'd0);
        sel = 1'b0;
        run(4'b0101, 24'd3328, 24'd3328, 24'd3328, 24'd1);
        chk_out("pwm2.wrap", 1'b1, 24'd0, 24'd0);

        kd = 1'b0; comp = 2'b01; duv = 2'b00;
        run(4'b1000, 24'd1665, 24'd0, 24'd0, 24'd0);
        chk_out("compress.d10", 1'b1, 24'd512, 24'd0);
        run(4'b1000, 24'd3328, 24'd0, 24'd0, 24'd0);
        chk_out("compress.wrap", 1'b1, 24'd0, 24'd0);
        duv = 2'b10;
        run(4'b1000, 24'd1665, 24'd0, 24'd0, 24'd0);
        chk_out("compress.d4", 1'b1, 24'd8, 24'd0);
        comp = 2'b11; duv = 2'b00;
        run(4'b1000, 24'd512, 24'd0, 24'd0, 24'd0);
        chk_out("decompress.d10", 1'b1, 24'd1665, 24'd0);
        comp = 2'b00;
        run(4'b1000, 24'd1234, 24'd5, 24'd6, 24'd7);
        chk_out("map.pass", 1'b1, 24'd1234, 24'd0);
        run(4'b0010, 24'd11, 24'd12, 24'd13, 24'd14);
        chk_out("badcode", 1'b1, 24'd0, 24'd0);

        kd = 1'b1; q = 24'd8380417; m = 25'd8396807; n = 5'd23; dcmp = 2'b01;
        run(4'b1000, 24'd200000, 24'd0, 24'd0, 24'd0);
        chk_out("dcmp.200000", 1'b1, 24'd1, 24'd9536);
        run(4'b1000, 24'd95232, 24'd0, 24'd0, 24'd0);
        chk_out("dcmp.half", 1'b1, 24'd0, 24'd95232);
        run(4'b1000, 24'd95233, 24'd0, 24'd0, 24'd0);
        chk_out("dcmp.neg", 1'b1, 24'd1, 24'd8285186);
        run(4'b1000, 24'd8380416, 24'd0, 24'd0, 24'd0);
        chk_out("dcmp.qm1", 1'b1, 24'd0, 24'd8380416);
        dcmp = 2'b11;
        run(4'b1000, 24'd200000, 24'd0, 24'd0, 24'd0);
        chk_out("dcmp16", 1'b1, 24'd0, 24'd200000);
        dcmp = 2'b00;
        run(4'b1000, 24'd777, 24'd0, 24'd0, 24'd0);
        chk_out("dcmp.none", 1'b1, 24'd777, 24'd0);

        kd = 1'b0; q = 24'd3329; m = 25'd5039; n = 5'd12;
        // enable 1,0,1
        issue(4'b0000, 24'd1, 24'd2, 24'd0, 24'd0);
        step();
        issue(4'b0000, 24'd10, 24'd20, 24'd3, 24'd4);
        repeat (LAT - 3) step();
        chk_out("gap.first", 1'b1, 24'd3, 24'd0);
        step();
        chk_out("gap.hold", 1'b0, 24'd3, 24'd0);
        step();
        chk_out("gap.second", 1'b1, 24'd30, 24'd7);

        // reset with two operations in flight
        issue(4'b0000, 24'd40, 24'd50, 24'd1, 24'd1);
        issue(4'b0000, 24'd60, 24'd70, 24'd1, 24'd1);
        rst_n = 1'b0;
        #1;
        chk_out("midreset", 1'b0, 24'd0, 24'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < int'(LAT) + 1; i++) begin
            step();
            chk("flush.valid", {47'd0, valid}, 48'd0);
        end
        run(4'b0000, 24'd3328, 24'd1, 24'd7, 24'd8);
        chk_out("recover", 1'b1, 24'd0, 24'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
